ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard on the shared PS2_CLK/PS2_DAT lines, then checks the device's acknowledge. It is the transmit counterpart of the keyboard receive path. It drives the lines open-drain through two low-enables; the top level ties each line low when its enable is high and releases it otherwise. While `busy` is high, the receive path ignores line activity.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: cycles the clock line is held low before the request-to-send (100 µs at 50 MHz).
- RTS_CYCLES, 50: cycles both lines are held low before the clock line is released.
- TIMEOUT_CYCLES, 750000: maximum cycles from the clock-line release to the end of the transfer (15 ms).

Ports:
- CLOCK_50  in  1  system clock. One clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- tx_data  in  8  byte to send; latched when `start` is accepted.
- ps2_clk_in  in  1  raw PS2_CLK line level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT line level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse at the end of every transfer, including failed ones.
- ack_error  out  1  device did not pull data low at the ACK edge; held until the next accepted `start`.
- timeout  out  1  transfer aborted by timeout; held until the next accepted `start`.

## Operation
Input conditioning:
- Each raw line passes through a 2-flop synchronizer.
- A falling edge (`fe`) is the synchronized clock going from 1 to 0, registered; this gives 3 cycles of detect latency.

Frame and parity:
- Frame is 11 bits: start (0), d0..d7 LSB first, odd parity, stop (1).
- Parity bit = ~^tx_data.
- Driving a 0 means `ps2_dat_oe`=1; driving a 1 means release.

States:
- IDLE: both enables 0, `busy` 0. On `start`: latch `tx_data`, clear `ack_error` and `timeout`, go to INHIBIT.
- INHIBIT: `clk_oe`=1, `dat_oe`=0, for INHIBIT_CYCLES cycles, then go to RTS.
- RTS: `clk_oe`=1, `dat_oe`=1 (start bit), for RTS_CYCLES cycles, then go to SEND. Clear the bit counter and the timeout counter.
- SEND: `clk_oe`=0.
  - On `fe` number k (k=1..8): drive d(k-1).
  - On `fe` 9: drive parity.
  - On `fe` 10: release data (stop bit), then go to ACK.
- ACK: on the next `fe`, sample synchronized data. A value of 1 sets `ack_error`. Go to WAIT_IDLE.
- WAIT_IDLE: when both synchronized lines are 1, go to FINISH.
- FINISH: `done`=1 for one cycle, go to IDLE.

Timeout:
- The counter runs in SEND, ACK and WAIT_IDLE.
- When it reaches TIMEOUT_CYCLES: release both lines, set `timeout`, go to FINISH.
- Timeout takes priority over an `fe` in the same cycle.

Other rules:
- `start` outside IDLE is ignored; `tx_data` changes after acceptance have no effect.
- Counter widths are `$clog2(param+1)`. All counters saturate and never wrap.
- Extra `fe` edges seen in WAIT_IDLE are ignored.

## Timing
Reset:
- Reset sampled at edge N: at N+1 both enables are 0, `busy`/`done`/`ack_error`/`timeout` are 0, and the state is IDLE.
- This holds even in mid-frame: the lines are released within one cycle, and no `done` is produced.

Handshake:
- `start` high at edge N in IDLE: `busy`=1 and `clk_oe`=1 at N+1.
- `dat_oe` rises INHIBIT_CYCLES cycles after `clk_oe` rises.
- `clk_oe` falls RTS_CYCLES cycles after that.

Data updates:
- `dat_oe` changes exactly one cycle after each internal `fe`, i.e. 4 cycles after the raw line fall.
- This is well inside the device clock-low half period of at least 30 µs.

End of transfer:
- `done` and the final `ack_error`/`timeout` values are valid in the same cycle.
- `busy` falls the cycle after `done`.
- A new `start` is accepted in the cycle `busy` is 0.

## Test plan
For these tests, INHIBIT_CYCLES=20, RTS_CYCLES=4 and TIMEOUT_CYCLES=2000. A device model clocks with a 40-cycle period and samples data on the rising edges.

- Send 0xED with the device acking → model receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1; `done` pulses once; `ack_error`=0; `timeout`=0.
- Send 0x01 → parity bit 0 observed on data after the 9th falling edge; clean ACK.
- Send 0xFF with the device holding data high at the 11th edge → `done` pulses with `ack_error`=1, and `ack_error` stays 1 until the next `start`.
- Device never clocks after the RTS phase → exactly 2000 cycles after `clk_oe` falls, both enables are 0, `timeout`=1 and `done` pulses.
- Assert `reset` at the 5th device falling edge → next cycle both enables are 0, all outputs are 0, and no `done` follows.
- Pulse `start` with 0x55 while `busy`, then again after `done` → the first is ignored; the second transfers 0x55 with parity 1; `tx_data` changed mid-frame does not alter the transmitted bits.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Host-side command bundle for the PS/2 host transmitter.
// master: issues start/tx_data, observes busy/done/ack_error/timeout; slave: the transmitter.
interface ps2_host_tx_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic       ack_error;
    logic       timeout;

    modport master (
        output start, tx_data,
        input  busy, done, ack_error, timeout
    );

    modport slave (
        input  start, tx_data,
        output busy, done, ack_error, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte and checks the device ACK.
// Ports: CLOCK_50, reset (sync, active-high), host (command bundle), raw line inputs, open-drain low-enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    ps2_host_tx_if.slave  host,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);
    localparam int PMAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE,
        FINISH
    } state_t;

    state_t        state;
    logic          clk_s1, clk_s2, clk_d;
    logic          dat_s1, dat_s2;
    logic          fe;
    logic [7:0]    data_q;
    logic [3:0]    bit_cnt;
    logic [PW-1:0] phase_cnt;
    logic [TW-1:0] to_cnt;

    // Idle lines float high, so the synchronizers reset to 1 to avoid
    // a spurious falling edge right after reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            fe     <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= ps2_dat_in;
            dat_s2 <= dat_s1;
            fe     <= clk_d & ~clk_s2;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= IDLE;
            ps2_clk_oe     <= 1'b0;
            ps2_dat_oe     <= 1'b0;
            host.busy      <= 1'b0;
            host.done      <= 1'b0;
            host.ack_error <= 1'b0;
            host.timeout   <= 1'b0;
            data_q         <= '0;
            bit_cnt        <= '0;
            phase_cnt      <= '0;
            to_cnt         <= '0;
        end else begin
            host.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.start) begin
                        data_q         <= host.tx_data;
                        host.ack_error <= 1'b0;
                        host.timeout   <= 1'b0;
                        host.busy      <= 1'b1;
                        ps2_clk_oe     <= 1'b1;
                        phase_cnt      <= '0;
                        state          <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (phase_cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        phase_cnt  <= '0;
                        state      <= RTS;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                RTS: begin
                    if (phase_cnt == RTS_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        bit_cnt    <= '0;
                        to_cnt     <= '0;
                        state      <= SEND;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                SEND, ACK, WAIT_IDLE: begin
                    // Timeout wins over any edge arriving in the same cycle.
                    if (to_cnt == TO_LAST) begin
                        ps2_clk_oe   <= 1'b0;
                        ps2_dat_oe   <= 1'b0;
                        host.timeout <= 1'b1;
                        host.done    <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (state == SEND && fe) begin
                            if (bit_cnt < 4'd8) begin
                                ps2_dat_oe <= ~data_q[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2_dat_oe <= ^data_q;
                            end else begin
                                ps2_dat_oe <= 1'b0;
                                state      <= ACK;
                            end
                            if (bit_cnt != 4'd10) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (state == ACK && fe) begin
                            host.ack_error <= dat_s2;
                            state          <= WAIT_IDLE;
                        end else if (state == WAIT_IDLE && clk_s2 && dat_s2) begin
                            host.done <= 1'b1;
                            state     <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    host.busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a 40-cycle PS/2 device model.
// Directed scenarios; each task compares DUT outputs against hand-computed values.
module tb_ps2_host_tx;
    logic clk = 1'b0;
    logic rst;
    logic dev_clk;
    logic dev_dat;
    logic ps2_clk_oe;
    logic ps2_dat_oe;
    logic ps2_clk_line;
    logic ps2_dat_line;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] rx_bits;
    logic        oe3;
    logic        oe4;

    ps2_host_tx_if bus ();

    assign ps2_clk_line = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_line = ~ps2_dat_oe & dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .RTS_CYCLES(4),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .host(bus),
        .ps2_clk_in(ps2_clk_line),
        .ps2_dat_in(ps2_dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_xfer(input logic [7:0] d);
        bus.tx_data = d;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_release(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s clk release: got none, need clk_oe=0 within 200", name);
        end
    endtask

    // Device: 20 cycles low, 20 high, samples data at each rising edge.
    // After the 10th rise it pulls data low as ACK if asked to.
    task automatic dev_frame(input int nfall, input bit ack);
        rx_bits = '1;
        tick(10);
        for (int k = 1; k <= nfall; k++) begin
            dev_clk = 1'b0;
            tick(3);
            if (k == 1) oe3 = ps2_dat_oe;
            tick(1);
            if (k == 1) oe4 = ps2_dat_oe;
            tick(16);
            dev_clk = 1'b1;
            rx_bits[k-1] = ps2_dat_line;
            if (k == 10 && ack) begin
                tick(10);
                dev_dat = 1'b0;
                tick(10);
            end else if (k == 11) begin
                dev_dat = 1'b1;
            end else begin
                tick(20);
            end
        end
    endtask

    task automatic finish_check(input string name, input logic exp_ack, input logic exp_to);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done: got none, need pulse within 300", name);
        end
        n_cmp++;
        if ({bus.ack_error, bus.timeout} !== {exp_ack, exp_to}) begin
            n_bad++;
            $display("FAIL %s ack/to: got %b%b, need %b%b", name,
                     bus.ack_error, bus.timeout, exp_ack, exp_to);
        end
        tick(1);
        n_cmp++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s after done: got done/busy %b%b, need 00", name,
                     bus.done, bus.busy);
        end
    endtask

    task automatic check_bits(input string name, input logic [10:0] exp);
        n_cmp++;
        if (rx_bits !== exp) begin
            n_bad++;
            $display("FAIL %s bits: got %b, need %b", name, rx_bits, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_cmp++;
        if ({ps2_clk_oe, ps2_dat_oe, bus.busy, bus.done, bus.ack_error, bus.timeout} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset outputs: got %b%b%b%b%b%b, need 000000",
                     ps2_clk_oe, ps2_dat_oe, bus.busy, bus.done, bus.ack_error, bus.timeout);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_ed();
        int n;
        start_xfer(8'hED);
        n_cmp++;
        if ({bus.busy, ps2_clk_oe, ps2_dat_oe} !== 3'b110) begin
            n_bad++;
            $display("FAIL ed accept: got busy/clk/dat %b%b%b, need 110",
                     bus.busy, ps2_clk_oe, ps2_dat_oe);
        end
        n = 0;
        while (!ps2_dat_oe && n < 100) begin
            tick(1);
            n++;
        end
        n_cmp++;
        if (n !== 20) begin
            n_bad++;
            $display("FAIL ed inhibit len: got %0d, need 20", n);
        end
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            tick(1);
            n++;
        end
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL ed rts len: got %0d, need 4", n);
        end
        dev_frame(11, 1'b1);
        n_cmp++;
        if ({oe3, oe4} !== 2'b10) begin
            n_bad++;
            $display("FAIL ed fe1 latency: got oe@3/oe@4 %b%b, need 10", oe3, oe4);
        end
        check_bits("ed", 11'b0_1_1_1110_1101);
        finish_check("ed", 1'b0, 1'b0);
    endtask

    task automatic test_parity_zero();
        start_xfer(8'h01);
        wait_release("p01");
        dev_frame(11, 1'b1);
        n_cmp++;
        if (rx_bits[8] !== 1'b0) begin
            n_bad++;
            $display("FAIL p01 parity: got %b, need 0", rx_bits[8]);
        end
        check_bits("p01", 11'b0_1_0_0000_0001);
        finish_check("p01", 1'b0, 1'b0);
    endtask

    task automatic test_ack_error();
        start_xfer(8'hFF);
        wait_release("nak");
        dev_frame(11, 1'b0);
        check_bits("nak", 11'b1_1_1_1111_1111);
        finish_check("nak", 1'b1, 1'b0);
        tick(20);
        n_cmp++;
        if (bus.ack_error !== 1'b1) begin
            n_bad++;
            $display("FAIL nak hold: got %b, need 1", bus.ack_error);
        end
    endtask

    task automatic test_busy_ignore();
        start_xfer(8'hA3);
        n_cmp++;
        if ({bus.busy, bus.ack_error} !== 2'b10) begin
            n_bad++;
            $display("FAIL ign clear: got busy/ack %b%b, need 10", bus.busy, bus.ack_error);
        end
        wait_release("ign");
        fork
            dev_frame(11, 1'b1);
            begin
                tick(100);
                start_xfer(8'h55);
            end
        join
        check_bits("ign", 11'b0_1_1_1010_0011);
        finish_check("ign", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        start_xfer(8'h55);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b accept: got busy %b, need 1", bus.busy);
        end
        wait_release("b2b");
        fork
            dev_frame(11, 1'b1);
            begin
                tick(150);
                bus.tx_data = 8'h00;
            end
        join
        check_bits("b2b", 11'b0_1_1_0101_0101);
        finish_check("b2b", 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        start_xfer(8'h3C);
        wait_release("to");
        tick(1999);
        n_cmp++;
        if ({bus.timeout, bus.done, ps2_dat_oe} !== 3'b001) begin
            n_bad++;
            $display("FAIL to early: got to/done/dat %b%b%b, need 001",
                     bus.timeout, bus.done, ps2_dat_oe);
        end
        tick(1);
        n_cmp++;
        if ({bus.timeout, bus.done, ps2_clk_oe, ps2_dat_oe} !== 4'b1100) begin
            n_bad++;
            $display("FAIL to fire: got to/done/clk/dat %b%b%b%b, need 1100",
                     bus.timeout, bus.done, ps2_clk_oe, ps2_dat_oe);
        end
        tick(1);
        n_cmp++;
        if ({bus.done, bus.busy, bus.timeout} !== 3'b001) begin
            n_bad++;
            $display("FAIL to after: got done/busy/to %b%b%b, need 001",
                     bus.done, bus.busy, bus.timeout);
        end
    endtask

    task automatic test_reset_midframe();
        int hits;
        start_xfer(8'h12);
        wait_release("rstm");
        tick(10);
        for (int k = 1; k <= 4; k++) begin
            dev_clk = 1'b0;
            tick(20);
            dev_clk = 1'b1;
            tick(20);
        end
        dev_clk = 1'b0;
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if ({ps2_clk_oe, ps2_dat_oe, bus.busy, bus.done, bus.ack_error, bus.timeout} !== 6'b0) begin
            n_bad++;
            $display("FAIL rstm outputs: got %b%b%b%b%b%b, need 000000",
                     ps2_clk_oe, ps2_dat_oe, bus.busy, bus.done, bus.ack_error, bus.timeout);
        end
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 19) dev_clk = 1'b1;
            tick(1);
            if (bus.done || bus.busy) hits++;
        end
        n_cmp++;
        if (hits !== 0) begin
            n_bad++;
            $display("FAIL rstm no done: got %0d active cycles, need 0", hits);
        end
    endtask

    initial begin
        rst = 1'b1;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        bus.start = 1'b0;
        bus.tx_data = 8'h00;
        test_reset();
        test_ed();
        test_parity_zero();
        test_ack_error();
        test_busy_ignore();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
